// File: rtl/ft232r_reg_bank.sv
// Register bank behind the FT232R command processor: level req/ack bus plus an error-report handshake.
// Reads and writes complete one cycle after the request is sampled; the requester holds its level until ack.
module ft232r_reg_bank #(
  parameter logic [15:0] P_ID       = 16'hF232,
  parameter int          P_NREG     = 8,
  parameter logic [15:0] P_BAD_DATA = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           logic_adr,
  input  logic [15:0]           logic_wr_data,
  input  logic                  logic_wr_req,
  input  logic                  logic_rd_req,
  output logic [15:0]           logic_rd_data,
  output logic                  logic_ack,
  input  logic                  err_req,
  input  logic [31:0]           err_data,
  output logic                  err_ack,
  output logic [15:0]           ctrl,
  output logic [15:0]           pulse,
  output logic [16*P_NREG-1:0]  gp_regs
);

  typedef enum logic {IDLE, ACK} bus_state_t;
  typedef enum logic {E_IDLE, E_ACK} err_state_t;

  bus_state_t  bus_state, bus_next;
  err_state_t  err_state, err_next;

  logic        bus_start;
  logic        err_start;
  logic        wr_en;
  logic [15:0] rd_mux;

  logic [15:0] scratch;
  logic [15:0] err_cnt;
  logic [15:0] err_lo;
  logic [15:0] err_hi;
  logic        err_seen;
  logic [15:0] gp [P_NREG];

  // Bus FSM: one access per request level; a new one needs both requests to drop first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state <= IDLE;
    end else begin
      bus_state <= bus_next;
    end
  end

  always_comb begin
    bus_next  = bus_state;
    bus_start = 1'b0;
    case (bus_state)
      IDLE: begin
        if (logic_wr_req || logic_rd_req) begin
          bus_next  = ACK;
          bus_start = 1'b1;
        end
      end
      ACK: begin
        if (!logic_wr_req && !logic_rd_req) begin
          bus_next = IDLE;
        end
      end
      default: bus_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_state <= E_IDLE;
    end else begin
      err_state <= err_next;
    end
  end

  always_comb begin
    err_next  = err_state;
    err_start = 1'b0;
    case (err_state)
      E_IDLE: begin
        if (err_req) begin
          err_next  = E_ACK;
          err_start = 1'b1;
        end
      end
      E_ACK: begin
        if (!err_req) begin
          err_next = E_IDLE;
        end
      end
      default: err_next = E_IDLE;
    endcase
  end

  assign logic_ack = (bus_state == ACK);
  assign err_ack   = (err_state == E_ACK);
  assign wr_en     = bus_start && logic_wr_req;

  // Read mux sees register state before this edge's write/capture, giving pre-write read data.
  always_comb begin
    rd_mux = P_BAD_DATA;
    case (logic_adr)
      12'h000: rd_mux = P_ID;
      12'h001: rd_mux = scratch;
      12'h002: rd_mux = ctrl;
      12'h003: rd_mux = 16'h0000;
      12'h004: rd_mux = err_cnt;
      12'h005: rd_mux = err_lo;
      12'h006: rd_mux = err_hi;
      12'h007: rd_mux = {15'b0, err_seen};
      default: begin
        for (int k = 0; k < P_NREG; k++) begin
          if (logic_adr == 12'h010 + 12'(k)) begin
            rd_mux = gp[k];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logic_rd_data <= '0;
      scratch       <= '0;
      ctrl          <= '0;
      pulse         <= '0;
      for (int k = 0; k < P_NREG; k++) begin
        gp[k] <= '0;
      end
    end else begin
      pulse <= '0;
      if (bus_start) begin
        logic_rd_data <= rd_mux;
      end
      if (wr_en) begin
        case (logic_adr)
          12'h001: scratch <= logic_wr_data;
          12'h002: ctrl    <= logic_wr_data;
          12'h003: pulse   <= logic_wr_data;
          default: ;
        endcase
        for (int k = 0; k < P_NREG; k++) begin
          if (logic_adr == 12'h010 + 12'(k)) begin
            gp[k] <= logic_wr_data;
          end
        end
      end
    end
  end

  // Capture beats a same-edge W1C so an error arriving during the clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_lo   <= '0;
      err_hi   <= '0;
      err_seen <= 1'b0;
    end else begin
      if (err_start) begin
        err_lo   <= err_data[15:0];
        err_hi   <= err_data[31:16];
        err_seen <= 1'b1;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end else if (wr_en && logic_adr == 12'h007 && logic_wr_data[0]) begin
        err_seen <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < P_NREG; g++) begin : g_gp_out
    assign gp_regs[16*g +: 16] = gp[g];
  end

endmodule

// File: tb/tb_ft232r_reg_bank.sv
// Randomised checks of ft232r_reg_bank against a register-map model kept in the bench.
module tb_ft232r_reg_bank;

  localparam int NREG = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [11:0]       logic_adr = '0;
  logic [15:0]       logic_wr_data = '0;
  logic              logic_wr_req = 1'b0;
  logic              logic_rd_req = 1'b0;
  logic [15:0]       logic_rd_data;
  logic              logic_ack;
  logic              err_req = 1'b0;
  logic [31:0]       err_data = '0;
  logic              err_ack;
  logic [15:0]       ctrl;
  logic [15:0]       pulse;
  logic [16*NREG-1:0] gp_regs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the register map as plain variables.
  logic [15:0] m_scratch, m_ctrl, m_cnt, m_lo, m_hi;
  logic        m_seen;
  logic [15:0] m_gp [NREG];

  ft232r_reg_bank #(.P_ID(16'hF232), .P_NREG(NREG), .P_BAD_DATA(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .logic_adr(logic_adr), .logic_wr_data(logic_wr_data),
    .logic_wr_req(logic_wr_req), .logic_rd_req(logic_rd_req),
    .logic_rd_data(logic_rd_data), .logic_ack(logic_ack),
    .err_req(err_req), .err_data(err_data), .err_ack(err_ack),
    .ctrl(ctrl), .pulse(pulse), .gp_regs(gp_regs)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_scratch = 0; m_ctrl = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_seen = 0;
    for (int k = 0; k < NREG; k++) m_gp[k] = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [11:0] a);
    if (a == 0) return 16'hF232;
    if (a == 1) return m_scratch;
    if (a == 2) return m_ctrl;
    if (a == 3) return 16'h0000;
    if (a == 4) return m_cnt;
    if (a == 5) return m_lo;
    if (a == 6) return m_hi;
    if (a == 7) return {15'b0, m_seen};
    if (a >= 16 && a < 16 + NREG) return m_gp[a - 16];
    return 16'hDEAD;
  endfunction

  task automatic m_apply(input logic wr, input logic [11:0] a, input logic [15:0] d,
                         input logic er, input logic [31:0] ed);
    if (er) begin
      m_lo = ed[15:0]; m_hi = ed[31:16]; m_seen = 1;
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
    end
    if (wr) begin
      if (a == 1) m_scratch = d;
      if (a == 2) m_ctrl = d;
      if (a == 7 && d[0] && !er) m_seen = 0;
      if (a >= 16 && a < 16 + NREG) m_gp[a - 16] = d;
    end
  endtask

  function automatic logic [16*NREG-1:0] m_gp_vec();
    logic [16*NREG-1:0] v;
    for (int k = 0; k < NREG; k++) v[16*k +: 16] = m_gp[k];
    return v;
  endfunction

  // One access: request levels raised together at a negedge, dropped one cycle later.
  task automatic xfer(input logic wr, input logic rd, input logic [11:0] a, input logic [15:0] d,
                      input logic er, input logic [31:0] ed,
                      output logic [15:0] rdata, output logic ack1, output logic ack0,
                      output logic [15:0] p1, output logic [15:0] p2,
                      output logic eack1, output logic eack0);
    @(negedge clk);
    logic_adr = a; logic_wr_data = d; logic_wr_req = wr; logic_rd_req = rd;
    err_req = er; err_data = ed;
    @(negedge clk);
    ack1 = logic_ack; rdata = logic_rd_data; p1 = pulse; eack1 = err_ack;
    logic_wr_req = 0; logic_rd_req = 0; err_req = 0;
    logic_adr = 12'($urandom);
    @(negedge clk);
    ack0 = logic_ack; p2 = pulse; eack0 = err_ack;
  endtask

  task automatic test_reset();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    n_cmp++; if (logic_ack !== 0 || err_ack !== 0) begin n_bad++; $display("FAIL reset_ack: ack=%b err_ack=%b want 0 0", logic_ack, err_ack); end
    n_cmp++; if (logic_rd_data !== 0 || ctrl !== 0 || pulse !== 0) begin n_bad++; $display("FAIL reset_out: rd=%h ctrl=%h pulse=%h want 0", logic_rd_data, ctrl, pulse); end
    n_cmp++; if (gp_regs !== '0) begin n_bad++; $display("FAIL reset_gp: got %h want 0", gp_regs); end
    xfer(0, 1, 12'h000, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'hF232) begin n_bad++; $display("FAIL read_id: got %h want f232", rd); end
    n_cmp++; if (a1 !== 1 || a0 !== 0) begin n_bad++; $display("FAIL id_ack_timing: got %b%b want 10", a1, a0); end
  endtask

  task automatic test_ctrl_gp();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    xfer(1, 0, 12'h002, 16'h1234, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    m_apply(1, 12'h002, 16'h1234, 0, 0);
    n_cmp++; if (ctrl !== 16'h1234) begin n_bad++; $display("FAIL ctrl_write: got %h want 1234", ctrl); end
    xfer(0, 1, 12'h002, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL ctrl_read: got %h want 1234", rd); end
    xfer(1, 0, 12'h017, 16'hBEEF, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    m_apply(1, 12'h017, 16'hBEEF, 0, 0);
    n_cmp++; if (gp_regs[127:112] !== 16'hBEEF) begin n_bad++; $display("FAIL gp7_write: got %h want beef", gp_regs[127:112]); end
  endtask

  task automatic test_pulse();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    xfer(1, 0, 12'h003, 16'h00A5, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (p1 !== 16'h00A5 || p2 !== 16'h0000) begin n_bad++; $display("FAIL pulse_shape: got %h then %h want 00a5 then 0000", p1, p2); end
    xfer(0, 1, 12'h003, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL pulse_read: got %h want 0000", rd); end
  endtask

  task automatic test_error();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    logic [15:0] want [4];
    want[0] = 16'h0001; want[1] = 16'h0001; want[2] = 16'hCAFE; want[3] = 16'h0001;
    xfer(0, 0, 12'h000, 0, 1, 32'hCAFE_0001, rd, a1, a0, p1, p2, e1, e0);
    m_apply(0, 0, 0, 1, 32'hCAFE_0001);
    n_cmp++; if (e1 !== 1 || e0 !== 0 || a1 !== 0) begin n_bad++; $display("FAIL err_handshake: eack=%b%b bus_ack=%b want 10 0", e1, e0, a1); end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1, 12'(4 + i), 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
      n_cmp++; if (rd !== want[i]) begin n_bad++; $display("FAIL err_reg_%0d: got %h want %h", 4 + i, rd, want[i]); end
    end
    xfer(1, 0, 12'h007, 16'h0001, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    m_apply(1, 12'h007, 16'h0001, 0, 0);
    xfer(0, 1, 12'h007, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL status_w1c: got %h want 0000", rd); end
  endtask

  task automatic test_saturate();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    @(negedge clk);
    force dut.err_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt;
    m_cnt = 16'hFFFF;
    xfer(0, 0, 0, 0, 1, 32'h1111_2222, rd, a1, a0, p1, p2, e1, e0);
    m_apply(0, 0, 0, 1, 32'h1111_2222);
    xfer(0, 1, 12'h004, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'hFFFF) begin n_bad++; $display("FAIL err_cnt_sat: got %h want ffff", rd); end
    xfer(1, 0, 12'h007, 16'h0001, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    m_apply(1, 12'h007, 16'h0001, 0, 0);
    // W1C and capture on the same edge, with a read of status returning the pre-capture value
    xfer(1, 1, 12'h007, 16'h0001, 1, 32'h3333_4444, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL status_precapture: got %h want 0000", rd); end
    m_apply(1, 12'h007, 16'h0001, 1, 32'h3333_4444);
    xfer(0, 1, 12'h007, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL set_wins: got %h want 0001", rd); end
  endtask

  task automatic test_unmapped_reset();
    logic [15:0] rd, p1, p2; logic a1, a0, e1, e0;
    xfer(0, 1, 12'h0FF, 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    n_cmp++; if (rd !== 16'hDEAD || a1 !== 1) begin n_bad++; $display("FAIL unmapped: got %h ack=%b want dead 1", rd, a1); end
    xfer(1, 0, 12'h002, 16'h5A5A, 0, 0, rd, a1, a0, p1, p2, e1, e0);
    @(negedge clk);
    logic_adr = 12'h002; logic_rd_req = 1;
    @(negedge clk);
    n_cmp++; if (logic_ack !== 1 || logic_rd_data !== 16'h5A5A) begin n_bad++; $display("FAIL pre_reset_read: ack=%b rd=%h want 1 5a5a", logic_ack, logic_rd_data); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (logic_ack !== 0 || ctrl !== 0 || logic_rd_data !== 0) begin n_bad++; $display("FAIL async_reset: ack=%b ctrl=%h rd=%h want 0 0 0", logic_ack, ctrl, logic_rd_data); end
    m_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (logic_ack !== 1 || logic_rd_data !== 16'h0000) begin n_bad++; $display("FAIL held_req_after_reset: ack=%b rd=%h want 1 0000", logic_ack, logic_rd_data); end
    logic_rd_req = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] rd, p1, p2, d, exp_rd; logic a1, a0, e1, e0, wr, rq, er;
    logic [11:0] a; logic [31:0] ed;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = 12'($urandom_range(0, 7));
        1, 2: a = 12'h010 + 12'($urandom_range(0, NREG - 1));
        default: a = 12'($urandom);
      endcase
      wr = 1'($urandom); rq = 1'($urandom); er = ($urandom_range(0, 3) == 0);
      if (!wr && !rq && !er) rq = 1;
      d = 16'($urandom); ed = $urandom;
      if (a == 7 && $urandom_range(0, 1) == 1) d[0] = 1;
      exp_rd = m_read(a);
      xfer(wr, rq, a, d, er, ed, rd, a1, a0, p1, p2, e1, e0);
      m_apply(wr, a, d, er, ed);
      n_cmp++;
      if ((wr || rq) && rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rd[%0d] adr=%h: got %h want %h", i, a, rd, exp_rd); end
      else if (a1 !== (wr | rq) || a0 !== 0) begin n_bad++; $display("FAIL rnd_ack[%0d]: got %b%b want %b0", i, a1, a0, wr | rq); end
      else if (e1 !== er || e0 !== 0) begin n_bad++; $display("FAIL rnd_eack[%0d]: got %b%b want %b0", i, e1, e0, er); end
      else if (p1 !== ((wr && a == 3) ? d : 16'h0) || p2 !== 0) begin n_bad++; $display("FAIL rnd_pulse[%0d]: got %h %h want %h 0", i, p1, p2, (wr && a == 3) ? d : 16'h0); end
      else if (ctrl !== m_ctrl || gp_regs !== m_gp_vec()) begin n_bad++; $display("FAIL rnd_regs[%0d]: ctrl %h want %h gp %h want %h", i, ctrl, m_ctrl, gp_regs, m_gp_vec()); end
    end
    for (int a2 = 4; a2 < 8; a2++) begin
      exp_rd = m_read(12'(a2));
      xfer(0, 1, 12'(a2), 0, 0, 0, rd, a1, a0, p1, p2, e1, e0);
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_final_%0d: got %h want %h", a2, rd, exp_rd); end
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_ctrl_gp();
    test_pulse();
    test_error();
    test_saturate();
    test_unmapped_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
